// File: rtl/map_drawer.sv
// map_drawer: raster sweep of the 160x120 background map.
// Streams one ROM pixel per cycle to the VGA adapter, then pulses done.
module map_drawer #(
    parameter int X_MAX    = 160,
    parameter int Y_MAX    = 120,
    parameter int COLOUR_W = 3
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                draw_map,
    output logic                draw_map_done,
    output logic [14:0]         rom_address,
    input  logic [COLOUR_W-1:0] rom_q,
    output logic [7:0]          vga_x,
    output logic [6:0]          vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_FLUSH = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    localparam logic [7:0] X_LAST = 8'(X_MAX - 1);
    localparam logic [6:0] Y_LAST = 7'(Y_MAX - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [7:0] vga_x_q, vga_x_d;
    logic [6:0] vga_y_q, vga_y_d;
    logic       plot_q, plot_d;

    // Next-state, sweep counters and plot register inputs.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        vga_x_d = vga_x_q;
        vga_y_d = vga_y_q;
        plot_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                x_d = 8'd0;
                y_d = 7'd0;
                if (draw_map) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!draw_map) begin
                    state_d = S_IDLE;
                end else begin
                    vga_x_d = x_q;
                    vga_y_d = y_q;
                    plot_d  = 1'b1;
                    if (x_q == X_LAST) begin
                        if (y_q == Y_LAST) begin
                            state_d = S_FLUSH;
                        end else begin
                            x_d = 8'd0;
                            y_d = y_q + 7'd1;
                        end
                    end else begin
                        x_d = x_q + 8'd1;
                    end
                end
            end
            S_FLUSH: begin
                state_d = draw_map ? S_DONE : S_IDLE;
            end
            S_DONE: begin
                state_d = draw_map ? S_HOLD : S_IDLE;
            end
            S_HOLD: begin
                if (!draw_map) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            x_q     <= 8'd0;
            y_q     <= 7'd0;
            vga_x_q <= 8'd0;
            vga_y_q <= 7'd0;
            plot_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            vga_x_q <= vga_x_d;
            vga_y_q <= vga_y_d;
            plot_q  <= plot_d;
        end
    end

    // y*160 + x as shifts; the largest value 19199 fits in 15 bits.
    assign rom_address = {1'b0, y_q, 7'b0}
                       + {3'b0, y_q, 5'b0}
                       + {7'b0, x_q};

    assign vga_x         = vga_x_q;
    assign vga_y         = vga_y_q;
    assign vga_plot      = plot_q;
    assign vga_colour    = rom_q;
    assign draw_map_done = (state_q == S_DONE);

endmodule
